// File: rtl/aes_round_ctrl_if.sv
// Request, datapath and result signals of the AES round controller.
// master = requester/datapath side, slave = controller.
interface aes_round_ctrl_if #(
  parameter int unsigned ROUND_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [127:0]       in_block;
  logic [255:0]       in_key;
  logic [1:0]         in_key_size;
  logic [127:0]       dp_in;
  logic [255:0]       dp_key;
  logic [ROUND_W-1:0] dp_counter;
  logic [ROUND_W-1:0] dp_max_round;
  logic [127:0]       dp_out;
  logic               out_valid;
  logic               out_ready;
  logic [127:0]       out_block;
  logic               busy;

  modport master (
    output in_valid, in_block, in_key, in_key_size, dp_out, out_ready,
    input  in_ready, dp_in, dp_key, dp_counter, dp_max_round, out_valid, out_block, busy
  );

  modport slave (
    input  in_valid, in_block, in_key, in_key_size, dp_out, out_ready,
    output in_ready, dp_in, dp_key, dp_counter, dp_max_round, out_valid, out_block, busy
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: latches a block/key, steps the round counter to 10/12/14,
// captures the datapath result. Optional abort input under AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl #(
  parameter int unsigned ROUND_W = 6
) (
  input  logic clk,
  input  logic rst_n,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic abort,
`endif
  aes_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [127:0]       in_q, in_d;
  logic [255:0]       key_q, key_d;
  logic [ROUND_W-1:0] cnt_q, cnt_d;
  logic [ROUND_W-1:0] max_q, max_d;
  logic [127:0]       out_q, out_d;
  logic               abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      in_q    <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      max_q   <= ROUND_W'(10);
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          in_d    = bus.in_block;
          key_d   = bus.in_key;
          cnt_d   = '0;
          state_d = RUN;
          unique case (bus.in_key_size)
            2'b00:   max_d = ROUND_W'(10);
            2'b01:   max_d = ROUND_W'(12);
            default: max_d = ROUND_W'(14);
          endcase
        end
      end
      RUN: begin
        if (cnt_q < max_q) begin
          cnt_d = cnt_q + ROUND_W'(1);
        end else begin
          out_d   = bus.dp_out;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over a completion landing on the same edge: result is dropped.
    if (abort_hit) begin
      state_d = IDLE;
      cnt_d   = '0;
      out_d   = out_q;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.busy         = (state_q == RUN) || (state_q == DONE);
  assign bus.dp_in        = in_q;
  assign bus.dp_key       = key_q;
  assign bus.dp_counter   = cnt_q;
  assign bus.dp_max_round = max_q;
  assign bus.out_block    = out_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed + randomized bench for aes_round_ctrl with a stand-in round datapath
// whose final-round output is predicted per transaction from key size.
module tb_aes_round_ctrl;

  logic clk;
  logic rst_n;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic abort;
`endif
  int errors = 0;
  int checks = 0;
  logic [127:0] last_out;

  aes_round_ctrl_if #(.ROUND_W(6)) bus ();

  aes_round_ctrl #(.ROUND_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mix(input logic [127:0] b, input logic [255:0] k, input int c);
    logic [7:0] cb;
    cb = 8'(c);
    return b ^ k[255:128] ^ {k[119:0], k[127:120]} ^ {16{cb}};
  endfunction

  function automatic int rounds(input logic [1:0] ks);
    if (ks == 2'b00) return 10;
    if (ks == 2'b01) return 12;
    return 14;
  endfunction

  assign bus.dp_out = mix(bus.dp_in, bus.dp_key, int'(bus.dp_counter));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    chk("rst_cnt", bus.dp_counter, 0);
    chk("rst_max", bus.dp_max_round, 10);
    chk("rst_in", bus.dp_in, 0);
    chk("rst_key", bus.dp_key, 0);
    chk("rst_out", bus.out_block, 0);
  endtask

  task automatic junk_inputs();
    bus.in_valid    = 1'($urandom);
    bus.in_block    = {$urandom, $urandom, $urandom, $urandom};
    bus.in_key      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.in_key_size = 2'($urandom);
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE with in_valid low.
  task automatic do_txn(input logic [127:0] blk, input logic [255:0] key, input logic [1:0] ks,
                        input int hold, input int rst_at, input int abort_at);
    int r;
    logic [127:0] exp;
    r   = rounds(ks);
    exp = mix(blk, key, r);
    chk("idle_ready", bus.in_ready, 1'b1);
    bus.in_valid    = 1'b1;
    bus.in_block    = blk;
    bus.in_key      = key;
    bus.in_key_size = ks;
    @(negedge clk);
    for (int n = 0; n <= r; n++) begin
      chk("run_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b001);
      chk("run_cnt", bus.dp_counter, n);
      chk("run_in", bus.dp_in, blk);
      chk("run_key", bus.dp_key, key);
      chk("run_max", bus.dp_max_round, r);
      junk_inputs();
      bus.out_ready = 1'($urandom);
      if (n == rst_at) begin
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset();
        last_out = '0;
        @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        return;
      end
`ifdef AES_ROUND_CTRL_ABORT_EN
      if (n == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
        chk("abort_cnt", bus.dp_counter, 0);
        chk("abort_out", bus.out_block, last_out);
        return;
      end
`endif
      @(negedge clk);
    end
    chk("done_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b011);
    chk("done_out", bus.out_block, exp);
    chk("done_cnt", bus.dp_counter, r);
    last_out = exp;
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      junk_inputs();
      @(negedge clk);
      chk("hold_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b011);
      chk("hold_out", bus.out_block, exp);
    end
    bus.out_ready = 1'b1;
    junk_inputs();
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("release_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    chk("release_no_accept", bus.dp_in, blk);
    chk("release_out", bus.out_block, exp);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("idle_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    chk("idle_cnt_hold", bus.dp_counter, r);
  endtask

  initial begin
    logic [127:0] pt;
    logic [255:0] k128, k192, k256;
    pt   = 128'h00112233445566778899aabbccddeeff;
    k128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    k192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    rst_n = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    bus.in_valid    = 1'b0;
    bus.in_block    = '0;
    bus.in_key      = '0;
    bus.in_key_size = 2'b00;
    bus.out_ready   = 1'b0;
    last_out        = '0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset();

    do_txn(pt, k128, 2'b00, 2, -1, -1);
    do_txn(pt, k256, 2'b10, 0, -1, -1);
    do_txn(pt, k256, 2'b11, 1, -1, -1);
    do_txn(pt, k192, 2'b01, 0, 5, -1);
    do_txn(pt, k192, 2'b01, 20, -1, -1);
    for (int i = 0; i < 6; i++) begin
      do_txn({$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             2'($urandom), int'($urandom_range(3)), -1, -1);
    end

`ifdef AES_ROUND_CTRL_ABORT_EN
    do_txn(pt, k128, 2'b00, 0, -1, 10);
    do_txn(pt, k256, 2'b10, 0, -1, 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_ignored", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    do_txn(pt, k192, 2'b01, 1, -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: ROUND_W, 6, width of round counter and max-round buses.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  request carries a block/key to encrypt.
REQ-005 Port: in_ready  output  1  controller can accept a request.
REQ-006 Port: in_block  input  128  plaintext.
REQ-007 Port: in_key  input  256  cipher key, MSB-aligned; 128/192-bit keys occupy the upper bits.
REQ-008 Port: in_key_size  input  2  00=128, 01=192, 10=256, 11=treated as 256.
REQ-009 Port: dp_in  output  128  plaintext register driven to round datapath.
REQ-010 Port: dp_key  output  256  key register driven to round datapath.
REQ-011 Port: dp_counter  output  ROUND_W  current round index to datapath.
REQ-012 Port: dp_max_round  output  ROUND_W  10/12/14 to datapath.
REQ-013 Port: dp_out  input  128  datapath round output.
REQ-014 Port: out_valid  output  1  ciphertext available.
REQ-015 Port: out_ready  input  1  consumer accepts ciphertext.
REQ-016 Port: out_block  output  128  registered ciphertext.
REQ-017 Port: busy  output  1  high in RUN or DONE.

Function
REQ-018 FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-019 IDLE: in_valid&in_ready at edge -> latch in_block into dp_in, in_key into dp_key, max round (10/12/14 from in_key_size) into dp_max_round, clear dp_counter to 0, enter RUN.
REQ-020 IDLE without in_valid: all registers hold.
REQ-021 RUN: dp_counter increments by 1 each cycle while dp_counter < dp_max_round.
REQ-022 RUN with dp_counter == dp_max_round: capture dp_out into out_block, enter DONE, dp_counter holds.
REQ-023 Latency: out_valid rises exactly dp_max_round+1 cycles after accept edge (11/13/15).
REQ-024 DONE: out_block and out_valid hold until out_ready high at an edge, then go IDLE; no new accept in that same cycle.
REQ-025 dp_in, dp_key, dp_max_round stable for entire RUN; in_* changes during RUN/DONE ignored.
REQ-026 dp_counter never exceeds dp_max_round; no wrap-around.
REQ-027 Back-to-back: next request accepted earliest one cycle after DONE->IDLE.

Reset
REQ-028 rst_n low asynchronously forces state IDLE, dp_counter 0, dp_max_round 10, dp_in/dp_key/out_block 0.
REQ-029 Reset mid-RUN or mid-DONE discards operation; out_valid low and in_ready high immediately.

Configuration
REQ-030 Macro AES_ROUND_CTRL_ABORT_EN adds input port abort (1 bit).
REQ-031 With macro: abort high at an edge in RUN or DONE -> IDLE, dp_counter 0, out_block unchanged, no out_valid; abort has priority over completion in the same cycle; ignored in IDLE.
REQ-032 Without macro: no abort port; operation always runs to DONE.

Verification
REQ-033 AES-128 key 000102..0f, block 00112233..ff -> out_valid 11 cycles after accept, out_block 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 AES-256 key 000102..1f, same block -> 15 cycles, out_block 8ea2b7ca516745bfeafc49904b496089; in_key_size=11 gives identical result.
REQ-035 out_ready held low 20 cycles in DONE -> out_block stable, in_ready low, in_valid ignored; out_ready high -> IDLE next cycle.
REQ-036 rst_n pulsed low at dp_counter=5 of AES-192 run -> immediate IDLE, all outputs at reset values, fresh request completes correctly.
REQ-037 With AES_ROUND_CTRL_ABORT_EN: abort at dp_counter==dp_max_round -> no out_valid, IDLE next cycle.
